pcs_tx_sequencer: RTL

Frame-to-XGMII sequencer for one 64-bit PCS TX lane. Accepts a valid/ready frame stream from the MAC side and produces one 64-bit data / 8-bit control word per clock in the codes the 64b/66b encoder consumes:

- start-with-preamble word
- aligned data words
- terminate words for every end position
- idle and LPI fill

It also enforces a minimum inter-frame gap and converts upstream underrun into an error word. One instance per lane sits directly in front of the PCS encoder.

---
 rtl/pcs_pkg.sv | 26 ++
 rtl/pcs_tx_sequencer_if.sv | 10 +
 rtl/pcs_term_word.sv | 16 +
 rtl/pcs_tx_sequencer.sv | 96 +++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// pcs_pkg: XGMII character codes, control masks and TX sequencer states shared by the PCS TX/RX blocks
package pcs_pkg;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_ERROR = 8'hFE;
    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_LPI   = 8'h06;
    localparam logic [7:0] CH_PRE   = 8'h55;
    localparam logic [7:0] CH_SFD   = 8'hD5;
    localparam logic [7:0] CTL_ALL   = 8'hFF;
    localparam logic [7:0] CTL_NONE  = 8'h00;
    localparam logic [7:0] CTL_START = 8'h01;
    localparam logic [63:0] WORD_IDLE  = {8{CH_IDLE}};
    localparam logic [63:0] WORD_LPI   = {8{CH_LPI}};
    localparam logic [63:0] WORD_ERROR = {8{CH_ERROR}};
    localparam logic [63:0] WORD_START = {CH_SFD, {6{CH_PRE}}, CH_START};
    localparam logic [63:0] WORD_TERM0 = {{7{CH_IDLE}}, CH_TERM};
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_TERM,
        ST_DRAIN,
        ST_IPG
    } seq_state_t;
endpackage

// File: rtl/pcs_tx_sequencer_if.sv
// pcs_tx_sequencer_if: MAC-side valid/ready frame stream feeding the PCS TX sequencer
interface pcs_tx_sequencer_if;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [3:0]  s_bytes;
    modport master (output s_data, s_valid, s_last, s_bytes, input s_ready);
    modport slave (input s_data, s_valid, s_last, s_bytes, output s_ready);
endinterface

// File: rtl/pcs_term_word.sv
// pcs_term_word: builds the XGMII terminate word for a last beat carrying n (1..7) valid bytes
module pcs_term_word
    import pcs_pkg::*;
(
    input  logic [63:0] beat,
    input  logic [2:0]  n,
    output logic [63:0] term_d,
    output logic [7:0]  term_c
);
    always_comb begin
        term_d = WORD_IDLE;
        for (int k = 0; k < 8; k++)
            term_d[8*k +: 8] = (k < int'(n)) ? beat[8*k +: 8] : (k == int'(n)) ? CH_TERM : CH_IDLE;
        term_c = CTL_ALL << n;
    end
endmodule

// File: rtl/pcs_tx_sequencer.sv
// pcs_tx_sequencer: frame stream to XGMII start/data/terminate/idle words for one 64-bit PCS TX lane.
// Define PCS_TX_SEQ_LPI_EN to emit LPI fill in IDLE while lpi_req is high.
module pcs_tx_sequencer
    import pcs_pkg::*;
#(
    parameter int IPG_WORDS = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pcs_tx_sequencer_if.slave    s,
    input  logic                 lpi_req,
    output logic [63:0]          tx_d,
    output logic [7:0]           tx_c,
    output logic [CNT_WIDTH-1:0] underrun_cnt
);
    localparam logic [3:0] GAP_LOAD = 4'(IPG_WORDS);
    seq_state_t  state;
    logic [3:0]  gap;
    logic [63:0] term_d;
    logic [7:0]  term_c;
    logic        full;
    logic        fill_lpi;
    // a byte count of 0 (or anything above 7) means the whole beat is payload
    assign full = s.s_bytes[3] || s.s_bytes[2:0] == 3'd0;
    assign s.s_ready = state == ST_DATA || state == ST_DRAIN;
`ifdef PCS_TX_SEQ_LPI_EN
    assign fill_lpi = lpi_req;
`else
    assign fill_lpi = 1'b0 & lpi_req;
`endif
    pcs_term_word u_term (
        .beat   (s.s_data),
        .n      (s.s_bytes[2:0]),
        .term_d (term_d),
        .term_c (term_c)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            gap          <= '0;
            tx_d         <= WORD_IDLE;
            tx_c         <= CTL_ALL;
            underrun_cnt <= '0;
        end else begin
            tx_d <= WORD_IDLE;
            tx_c <= CTL_ALL;
            case (state)
                ST_IDLE: begin
                    if (s.s_valid)
                        state <= ST_START;
                    else if (fill_lpi)
                        tx_d <= WORD_LPI;
                end
                ST_START: begin
                    tx_d  <= WORD_START;
                    tx_c  <= CTL_START;
                    state <= ST_DATA;
                end
                ST_DATA: begin
                    if (!s.s_valid) begin
                        tx_d  <= WORD_ERROR;
                        state <= ST_DRAIN;
                        if (!(&underrun_cnt))
                            underrun_cnt <= underrun_cnt + 1'b1;
                    end else if (s.s_last && !full) begin
                        tx_d  <= term_d;
                        tx_c  <= term_c;
                        gap   <= GAP_LOAD;
                        state <= ST_IPG;
                    end else begin
                        tx_d  <= s.s_data;
                        tx_c  <= CTL_NONE;
                        state <= s.s_last ? ST_TERM : ST_DATA;
                    end
                end
                ST_TERM: begin
                    tx_d  <= WORD_TERM0;
                    gap   <= GAP_LOAD;
                    state <= ST_IPG;
                end
                ST_DRAIN: begin
                    if (s.s_valid && s.s_last) begin
                        gap   <= GAP_LOAD;
                        state <= ST_IPG;
                    end
                end
                ST_IPG: begin
                    gap   <= gap - 1'b1;
                    state <= (gap <= 4'd1) ? ST_IDLE : ST_IPG;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
